// File: rtl/rv_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and the canonical NOP,
// reused by the fetch stage today and the decode stage later.
package rv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam int unsigned TmrW = 8;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for bounded waits on instruction memory; term_o flags the
// last allowed cycle so the owner can bail out on the same edge.
module fetch_timeout_ctr
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [TmrW-1:0] TermCnt = TmrW'(TIMEOUT - 1);

  logic [TmrW-1:0] count_d, count_q;

  assign term_o = (count_q == TermCnt);

  // Clear wins so a fresh wait always starts from zero; hold at terminal.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !term_o) begin
      count_d = count_q + TmrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word request to instruction memory, a single
// holding slot toward decode, and pc_we to advance the PC on consumption.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          TIMEOUT   = 64,
  parameter logic [DATA_W-1:0]    NOP_INSTR = DATA_W'(NopInstr)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en_i,
  input  logic [ADDR_W-1:0] pc_in_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_fault_o,
  output logic              pc_we_o
);

  fetch_state_e      state_d, state_q;
  logic [DATA_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              fault_d, fault_q;
  logic              tmr_clr, tmr_en, tmr_term;
  logic              aligned;

  assign aligned     = (pc_in_i[1:0] == 2'b00);
  assign imem_addr_o = pc_in_i;
  assign instr_o     = instr_q;
  assign instr_pc_o  = pc_q;
  assign instr_fault_o = fault_q;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_o (tmr_term)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    pc_we_o       = 1'b0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        imem_req_o = fetch_en_i && !flush_i && aligned;
        if (imem_req_o && imem_gnt_i) begin
          pc_d    = pc_in_i;
          tmr_clr = 1'b1;
          state_d = StWait;
        end else if (fetch_en_i && !flush_i && !aligned) begin
          // Misaligned PC never reaches memory; hand decode a faulting NOP.
          pc_d    = pc_in_i;
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          state_d = StHold;
        end
      end

      StWait: begin
        tmr_en = 1'b1;
        if (flush_i) begin
          if (imem_rvalid_i) begin
            state_d = StIdle;
          end else begin
            tmr_clr = 1'b1;
            state_d = StDrain;
          end
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          fault_d = 1'b0;
          state_d = StHold;
        end else if (tmr_term) begin
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          state_d = StHold;
        end
      end

      StHold: begin
        instr_valid_o = 1'b1;
        if (flush_i) begin
          state_d = StIdle;
        end else if (instr_ready_i) begin
          pc_we_o = 1'b1;
          state_d = StIdle;
        end
      end

      StDrain: begin
        // The squashed request still owes one response; swallow it.
        tmr_en = 1'b1;
        if (imem_rvalid_i || tmr_term) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      instr_q <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected
// instructions popped whenever decode accepts one.
module tb_instr_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc_in;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        pc_we;

  int   checks      = 0;
  int   failures    = 0;
  int   exp_accepts = 0;
  int   acc_seen    = 0;
  bit   mon_en      = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .TIMEOUT   (4),
    .NOP_INSTR (Nop)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en_i    (fetch_en),
    .pc_in_i       (pc_in),
    .flush_i       (flush),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_fault_o (instr_fault),
    .pc_we_o       (pc_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // pc_we must track the accept handshake exactly; accepts drain the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pc_we_rule", 32'(pc_we), 32'(instr_valid & instr_ready & ~flush));
      if (instr_valid && instr_ready && !flush) begin
        acc_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_accept", 32'(instr_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_instr", instr, e.instr);
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_fault", 32'(instr_fault), 32'(e.fault));
        end
      end
    end
  end

  task automatic hold(input logic [31:0] data, input logic [31:0] pc, input logic fault,
                      input int rdy_dly);
    instr_ready = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, data);
      chk("hold_pc", instr_pc, pc);
      chk("hold_fault", 32'(instr_fault), 32'(fault));
      chk("hold_no_pcwe", 32'(pc_we), 32'd0);
      next_cyc();
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("acc_valid", 32'(instr_valid), 32'd1);
    chk("acc_pcwe", 32'(pc_we), 32'd1);
    next_cyc();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("post_acc_valid", 32'(instr_valid), 32'd0);
    chk("post_acc_pcwe", 32'(pc_we), 32'd0);
    next_cyc();
  endtask

  task automatic fetch(input logic [31:0] pc, input int gnt_dly, input int rv_dly,
                       input logic [31:0] data, input int rdy_dly);
    fetch_en = 1'b1;
    pc_in    = pc;
    imem_gnt = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("req_addr", imem_addr, pc);
      chk("idle_no_valid", 32'(instr_valid), 32'd0);
      next_cyc();
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("req_gnt", 32'(imem_req), 32'd1);
    chk("addr_gnt", imem_addr, pc);
    sb.push_back('{instr: data, pc: pc, fault: 1'b0});
    exp_accepts++;
    next_cyc();
    imem_gnt = 1'b0;
    fetch_en = 1'b0;
    for (int i = 1; i < rv_dly; i++) begin
      @(negedge clk);
      chk("wait_no_req", 32'(imem_req), 32'd0);
      chk("wait_no_valid", 32'(instr_valid), 32'd0);
      next_cyc();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    chk("rvalid_no_valid", 32'(instr_valid), 32'd0);
    next_cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    hold(data, pc, 1'b0, rdy_dly);
  endtask

  // Issue a granted request and leave the DUT in WAIT at the next drive point.
  task automatic grant_only(input logic [31:0] pc);
    fetch_en = 1'b1;
    pc_in    = pc;
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("grant_req", 32'(imem_req), 32'd1);
    next_cyc();
    imem_gnt = 1'b0;
    fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    fetch_en    = 1'b0;
    pc_in       = '0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pcwe", 32'(pc_we), 32'd0);
    chk("rst_fault", 32'(instr_fault), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    next_cyc();

    fetch(32'h0000_0004, 0, 2, 32'h00A0_0093, 0);
    fetch(32'h0000_0008, 3, 2, 32'h00C0_0113, 4);

    // Misaligned PC: no memory traffic, faulting NOP straight to HOLD.
    fetch_en = 1'b1;
    pc_in    = 32'h0000_0006;
    @(negedge clk);
    chk("misal_no_req", 32'(imem_req), 32'd0);
    sb.push_back('{instr: Nop, pc: 32'h0000_0006, fault: 1'b1});
    exp_accepts++;
    next_cyc();
    fetch_en = 1'b0;
    hold(Nop, 32'h0000_0006, 1'b1, 1);

    // Flush in WAIT, late response must be drained and discarded.
    grant_only(32'h0000_0010);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_valid", 32'(instr_valid), 32'd0);
    next_cyc();
    flush       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("drain_valid", 32'(instr_valid), 32'd0);
    next_cyc();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("after_drain_valid", 32'(instr_valid), 32'd0);
    chk("after_drain_req", 32'(imem_req), 32'd0);
    next_cyc();
    fetch(32'h0000_0010, 0, 1, 32'h0010_0113, 0);

    // Flush together with rvalid goes straight to IDLE: next request issues at once.
    grant_only(32'h0000_0014);
    flush       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("flush_rv_valid", 32'(instr_valid), 32'd0);
    next_cyc();
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    fetch(32'h0000_0014, 0, 1, 32'h0020_0193, 0);

    // No response: faulting NOP after exactly four WAIT cycles.
    grant_only(32'h0000_0020);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo_wait_valid", 32'(instr_valid), 32'd0);
      next_cyc();
    end
    sb.push_back('{instr: Nop, pc: 32'h0000_0020, fault: 1'b1});
    exp_accepts++;
    hold(Nop, 32'h0000_0020, 1'b1, 2);

    // Reset during WAIT, then a stray response must be ignored.
    grant_only(32'h0000_0030);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_valid", 32'(instr_valid), 32'd0);
    next_cyc();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stray_valid", 32'(instr_valid), 32'd0);
    chk("stray_req", 32'(imem_req), 32'd0);
    next_cyc();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("post_stray_valid", 32'(instr_valid), 32'd0);
    chk("post_stray_instr", instr, 32'd0);
    chk("post_stray_pc", instr_pc, 32'd0);
    chk("post_stray_fault", 32'(instr_fault), 32'd0);
    next_cyc();
    fetch(32'h0000_0030, 1, 1, 32'h0030_0213, 1);

    @(negedge clk);
    chk("accept_count", 32'(acc_seen), 32'(exp_accepts));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
